// File: rtl/inv_shiftrows_stream.sv
// Streaming InvShiftRows: gathers four 32-bit column words into a 128-bit
// AES state and emits the row-rotated state with a valid/ready handshake.
module inv_shiftrows_stream #(
  parameter bit BYPASS = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_word,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out
);

  logic [1:0]   cnt;
  logic [95:0]  gather;
  logic         in_beat;
  logic         last_beat;
  logic [127:0] assembled;
  logic [127:0] permuted;
  logic [127:0] next_out;
  int unsigned  src;

  // Stall only the final word, and only while the output slot is still occupied.
  always_comb begin
    in_ready  = !((cnt == 2'd3) && out_valid && !out_ready);
    in_beat   = in_valid && in_ready;
    last_beat = in_beat && (cnt == 2'd3);
    assembled = {gather, in_word};
  end

  // Byte k = 4*col + row takes its source from column (col - row) mod 4.
  always_comb begin
    permuted = '0;
    src      = 0;
    for (int unsigned k = 0; k < 16; k++) begin
      src = 4 * (((k / 4) - (k % 4)) & 32'd3) + (k % 4);
      permuted[127 - 8*k -: 8] = assembled[127 - 8*src -: 8];
    end
    next_out = BYPASS ? assembled : permuted;
  end

  // Beat counter and gather register for columns 0..2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      gather <= '0;
    end else if (in_beat) begin
      cnt <= cnt + 2'd1;
      case (cnt)
        2'd0:    gather[95:64] <= in_word;
        2'd1:    gather[63:32] <= in_word;
        2'd2:    gather[31:0]  <= in_word;
        default: ;
      endcase
    end
  end

  // Output register: a new state loads on the final word, even in the same
  // cycle the previous state is consumed, so back-to-back states see no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
    end else if (last_beat) begin
      out_valid <= 1'b1;
      out       <= next_out;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inv_shiftrows_stream.sv
// Self-checking bench for inv_shiftrows_stream: vector table, directed
// handshake/reset sequences and a randomized scoreboard run.
module tb_inv_shiftrows_stream;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [31:0]  in_word = '0;
  logic         in_ready, out_valid, in_ready_b, out_valid_b;
  logic [127:0] out, out_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inv_shiftrows_stream #(.BYPASS(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  inv_shiftrows_stream #(.BYPASS(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_word(in_word), .out_valid(out_valid_b), .out_ready(out_ready), .out(out_b)
  );

  typedef struct {
    string        name;
    logic [127:0] words;
    logic [127:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: view the state as a 4x4 byte matrix and rotate row r right by r.
  function automatic logic [127:0] ref_isr(input logic [127:0] s);
    logic [7:0]   m[4][4];
    logic [7:0]   t[4][4];
    logic [127:0] r;
    r = '0;
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++)
        m[row][col] = s[127 - 8*(4*col + row) -: 8];
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++)
        t[row][(col + row) % 4] = m[row][col];
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++)
        r[127 - 8*(4*col + row) -: 8] = t[row][col];
    return r;
  endfunction

  // Feed four words on consecutive cycles (caller guarantees in_ready).
  task automatic feed_state(input logic [127:0] s);
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1;
      in_word  = s[127 - 32*j -: 32];
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #100000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tbl[3];
    logic [127:0] st_a, st_c, st_d, st_e;
    logic [127:0] expq[$];
    logic [31:0]  acc[$];
    logic [127:0] bb[3];
    int           sent, got, cyc;

    tbl[0] = '{"basic", 128'h00010203_04050607_08090a0b_0c0d0e0f,
                        128'h000d0a07_04010e0b_0805020f_0c090603};
    tbl[1] = '{"inverse", 128'h00050a0f_04090e03_080d0207_0c01060b,
                          128'h00010203_04050607_08090a0b_0c0d0e0f};
    tbl[2] = '{"pattern", 128'h00112233_44556677_8899aabb_ccddeeff,
                          128'h00ddaa77_4411eebb_885522ff_cc996633};

    // Reset state; in beats during reset must be ignored.
    in_valid = 1'b1;
    in_word  = 32'hAAAA_AAAA;
    #1;
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out", out, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    tick();
    tick();
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Vector table, out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      feed_state(tbl[i].words);
      chk({tbl[i].name, "_valid"}, {127'd0, out_valid}, 128'd1);
      chk({tbl[i].name, "_out"}, out, tbl[i].exp);
      chk({tbl[i].name, "_bypass"}, out_b, tbl[i].words);
      tick();
      chk({tbl[i].name, "_drain"}, {127'd0, out_valid}, 128'd0);
    end

    // Backpressure: second state's last word stalls until the first is taken.
    out_ready = 1'b0;
    feed_state(tbl[0].words);
    chk("bp_first_valid", {127'd0, out_valid}, 128'd1);
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1;
      in_word  = tbl[1].words[127 - 32*j -: 32];
      #1;
      chk("bp_ready_early", {127'd0, in_ready}, 128'd1);
      tick();
    end
    in_word = tbl[1].words[31:0];
    #1;
    chk("bp_ready_drop", {127'd0, in_ready}, 128'd0);
    for (int j = 0; j < 2; j++) begin
      tick();
      chk("bp_hold_out", out, tbl[0].exp);
      chk("bp_hold_valid", {127'd0, out_valid}, 128'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_release", {127'd0, in_ready}, 128'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_second_valid", {127'd0, out_valid}, 128'd1);
    chk("bp_second_out", out, tbl[1].exp);
    tick();
    chk("bp_second_drain", {127'd0, out_valid}, 128'd0);

    // Back-to-back streaming: valid every 4th cycle, in_ready never drops.
    for (int s = 0; s < 3; s++) bb[s] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_word  = bb[i/4][127 - 32*(i%4) -: 32];
      #1;
      chk("b2b_in_ready", {127'd0, in_ready}, 128'd1);
      tick();
      chk("b2b_valid", {127'd0, out_valid}, {127'd0, (i % 4) == 3});
      if ((i % 4) == 3) chk("b2b_out", out, ref_isr(bb[i/4]));
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_drain", {127'd0, out_valid}, 128'd0);

    // Asynchronous reset mid-block with an undelivered output pending.
    st_a = 128'h01020304_05060708_090a0b0c_0d0e0f10;
    out_ready = 1'b0;
    feed_state(st_a);
    chk("mr_pending", {127'd0, out_valid}, 128'd1);
    st_c = {$urandom, $urandom, $urandom, $urandom};
    for (int j = 0; j < 2; j++) begin
      in_valid = 1'b1;
      in_word  = st_c[127 - 32*j -: 32];
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid_now", {127'd0, out_valid}, 128'd0);
    chk("mr_out_now", out, 128'd0);
    chk("mr_bypass_now", out_b, 128'd0);
    chk("mr_in_ready", {127'd0, in_ready}, 128'd1);
    #3;
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    st_d = 128'hf0e0d0c0_b0a09080_70605040_30201000;
    feed_state(st_d);
    chk("mr_fresh_valid", {127'd0, out_valid}, 128'd1);
    chk("mr_fresh_out", out, ref_isr(st_d));
    tick();

    // Randomized traffic against a queue-based scoreboard.
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 20 && cyc < 3000) begin
      in_valid  = (sent < 80) && ($urandom_range(0, 9) < 7);
      in_word   = $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
      #1;
      chk("rand_valid", {127'd0, out_valid}, {127'd0, expq.size() != 0});
      chk("rand_in_ready", {127'd0, in_ready},
          {127'd0, !(acc.size() == 3 && expq.size() != 0 && !out_ready)});
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("rand_spurious", {127'd0, out_valid}, 128'd0);
        end else begin
          st_e = expq.pop_front();
          chk("rand_out", out, st_e);
          got++;
        end
      end
      if (in_valid && in_ready) begin
        acc.push_back(in_word);
        sent++;
        if (acc.size() == 4) begin
          expq.push_back(ref_isr({acc[0], acc[1], acc[2], acc[3]}));
          acc.delete();
        end
      end
      tick();
      cyc++;
    end
    chk("rand_count", 128'(got), 128'd20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_shiftrows_stream.md
INV_SHIFTROWS_STREAM -- requirements
Module: inv_shiftrows_stream

Interface
REQ-001 SHALL have parameter BYPASS, default 0, meaning 1 = emit assembled state unpermuted (debug), 0 = apply InvShiftRows.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  in_word carries a valid column word.
REQ-005 SHALL have port in_ready  output  1  block accepts in_word this cycle.
REQ-006 SHALL have port in_word  input  32  one state column, bits [31:24] = row 0 … [7:0] = row 3.
REQ-007 SHALL have port out_valid  output  1  out holds a completed 128-bit state.
REQ-008 SHALL have port out_ready  input  1  downstream consumes out this cycle.
REQ-009 SHALL have port out  output  128  permuted state, column-major, byte Gk at bits [127-8k -: 8].

Function
REQ-010 SHALL accept a word only on the rising edge where in_valid && in_ready ("in beat"); SHALL transfer out only where out_valid && out_ready ("out beat").
REQ-011 SHALL assemble one state from 4 in beats: beat 0 = column 0 (G0..G3), beat 1 = column 1, beat 2 = column 2, beat 3 = column 3.
REQ-012 SHALL track position with a 2-bit beat counter (0..3), incremented per in beat, wrapping 3 -> 0.
REQ-013 SHALL hold beats 0-2 in a 96-bit gather register; beat 3 SHALL NOT be stored there but combined directly into the output register load.
REQ-014 With BYPASS=0, SHALL load out = {G0,G13,G10,G7, G4,G1,G14,G11, G8,G5,G2,G15, G12,G9,G6,G3} (InvShiftRows: row r rotated right by r).
REQ-015 With BYPASS=1, SHALL load out = {G0..G15} unchanged.
REQ-016 SHALL assert out_valid on the cycle after the beat-3 in beat (latency 1 clock from last word to out_valid).
REQ-017 SHALL hold out and out_valid stable while out_valid && !out_ready.
REQ-018 SHALL clear out_valid after an out beat unless a new state loads on the same edge.
REQ-019 in_ready SHALL be 0 only when counter = 3 && out_valid && !out_ready; otherwise 1 (beats 0-2 accepted regardless of output stall).
REQ-020 Simultaneous out beat and beat-3 in beat: SHALL load the new state and keep out_valid = 1 (no bubble); sustained throughput one state per 4 clocks.
REQ-021 in_ready SHALL NOT depend combinationally on in_valid; out_valid SHALL NOT depend combinationally on out_ready.
REQ-022 in_valid low mid-block SHALL pause assembly with counter and gather register unchanged; no timeout.
REQ-023 in_word SHALL be ignored on cycles without an in beat.

Reset
REQ-024 rst_n low SHALL immediately force out_valid = 0, out = 128'h0, counter = 0, gather register = 0, independent of clk.
REQ-025 rst_n low mid-block SHALL discard the partial state and any undelivered output; the first in beat after release is column 0.
REQ-026 During reset in_ready SHALL read 1; in beats SHALL be ignored until the first rising edge with rst_n high.

Verification
REQ-027 Basic: reset, out_ready=1, words 00010203,04050607,08090a0b,0c0d0e0f on consecutive cycles -> next cycle out_valid=1, out=000d0a07_04010e0b_0805020f_0c090603.
REQ-028 Inverse check: feed ShiftRows output 00050a0f_04090e03_080d0207_0c01060b -> out = 00010203_04050607_08090a0b_0c0d0e0f.
REQ-029 Backpressure: out_ready=0 after first state, send second state -> in_ready drops at beat 3, first out held unchanged; raise out_ready -> first out beat, second state appears next cycle, no word lost.
REQ-030 Back-to-back: out_ready=1, 3 states streamed with in_valid always high -> out_valid pulses exactly every 4th cycle, in_ready never drops.
REQ-031 Reset mid-block: 2 words in, pulse rst_n low asynchronously -> out_valid=0, out=0 at once; then 4 fresh words -> correct state from those 4 only.
REQ-032 BYPASS=1 build with REQ-027 stimulus -> out = 00010203_04050607_08090a0b_0c0d0e0f.
